// File: rtl/ps2_kbd.sv
// PS/2 keyboard receiver with scancode FIFO and DATA/STATUS bus slave registers.
// Optional frame-stall timeout is enabled by defining PS2_TIMEOUT_EN.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef SLAVE_WIDTH
`define SLAVE_WIDTH 20
`endif

// state    | meaning
// S_IDLE   | waiting for a start bit (data = 0 on a falling ps2_clk)
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | sampling the odd-parity bit
// S_STOP   | sampling the stop bit; push or flag an error
module ps2_kbd #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ps2_clk,
  input  logic                            ps2_data,
  input  logic                            bus_req,
  input  logic                            bus_wen,
  input  logic [2:0]                      bus_mode,
  input  logic [`XLEN-`SLAVE_WIDTH-1:0]   bus_addr,
  input  logic [`XLEN-1:0]                bus_dat_i,
  output logic [`XLEN-1:0]                bus_dat_o,
  output logic                            bus_ready
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BAW = `XLEN - `SLAVE_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev, clk_s, bit_s, fall;

  state_t     state, state_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic [2:0] bitcnt, bitcnt_nxt;
  logic       par_ok, par_ok_nxt;
  logic       push, perr_set, tout_set;

  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr, count;
  logic        full, empty, pop, push_ok, ovf_set;
  logic        ovf, perr, tout;
  logic [7:0]  head, cnt8;

  logic            acc, w1c;
  logic [`XLEN-1:0] status, rd_data;
  logic            unused_bits;

  // synchronisers idle high so reset never fakes a falling edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_s;
    end
  end

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign bit_s = data_sync[SYNC_STAGES-1];
  assign fall  = clk_prev & ~clk_s;

`ifdef PS2_TIMEOUT_EN
  logic [15:0] tcnt;
  logic        timeout;

  always_ff @(posedge clk) begin
    if (!rst || fall || state == S_IDLE) tcnt <= '0;
    else                                 tcnt <= tcnt + 16'd1;
  end

  assign timeout = (state != S_IDLE) && (tcnt >= 16'(TIMEOUT_CYCLES));
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      par_ok <= 1'b0;
    end else begin
      state  <= state_nxt;
      shreg  <= shreg_nxt;
      bitcnt <= bitcnt_nxt;
      par_ok <= par_ok_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    bitcnt_nxt = bitcnt;
    par_ok_nxt = par_ok;
    push       = 1'b0;
    perr_set   = 1'b0;
    tout_set   = 1'b0;
    if (fall) begin
      case (state)
        S_IDLE: begin
          if (!bit_s) begin
            state_nxt  = S_DATA;
            bitcnt_nxt = '0;
          end
        end
        S_DATA: begin
          shreg_nxt  = {bit_s, shreg[7:1]};
          bitcnt_nxt = bitcnt + 3'd1;
          if (bitcnt == 3'd7) state_nxt = S_PARITY;
        end
        S_PARITY: begin
          par_ok_nxt = (^shreg) ^ bit_s;
          state_nxt  = S_STOP;
        end
        default: begin
          state_nxt = S_IDLE;
          if (bit_s && par_ok) push = 1'b1;
          else                 perr_set = 1'b1;
        end
      endcase
    end
`ifdef PS2_TIMEOUT_EN
    else if (timeout) begin
      state_nxt = S_IDLE;
      tout_set  = 1'b1;
    end
`endif
  end

  assign count   = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign cnt8    = 8'(count);
  assign head    = mem[rptr[AW-1:0]];

  // a new request is accepted only while no response is in flight
  assign acc     = bus_req & ~bus_ready;
  assign pop     = acc & ~bus_wen & ~bus_addr[2] & ~empty;
  assign w1c     = acc & bus_wen & bus_addr[2];
  assign push_ok = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      ovf  <= 1'b0;
      perr <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      ovf  <= ovf_set  | (ovf  & ~(w1c & bus_dat_i[2]));
      perr <= perr_set | (perr & ~(w1c & bus_dat_i[3]));
    end
  end

`ifdef PS2_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst) tout <= 1'b0;
    else      tout <= tout_set | (tout & ~(w1c & bus_dat_i[4]));
  end
`else
  assign tout = 1'b0;
`endif

  assign status = `XLEN'({cnt8, 3'b000, tout, perr, ovf, full, ~empty});

  always_comb begin
    rd_data = '0;
    if (!bus_wen) begin
      if (bus_addr[2])  rd_data = status;
      else if (!empty)  rd_data = `XLEN'(head);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus_ready <= 1'b0;
      bus_dat_o <= '0;
    end else begin
      bus_ready <= acc;
      bus_dat_o <= acc ? rd_data : '0;
    end
  end

  assign unused_bits = ^{bus_mode, bus_dat_i[`XLEN-1:5], bus_dat_i[1:0],
                         bus_addr[BAW-1:3], bus_addr[1:0], tout_set};

endmodule

// File: tb/tb_ps2_kbd.sv
// Directed bench for ps2_kbd: PS/2 frames in, DATA/STATUS bus reads out.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef SLAVE_WIDTH
`define SLAVE_WIDTH 20
`endif

module tb_ps2_kbd;
  localparam int BAW = `XLEN - `SLAVE_WIDTH;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 ps2_clk = 1'b1;
  logic                 ps2_data = 1'b1;
  logic                 bus_req = 1'b0;
  logic                 bus_wen = 1'b0;
  logic [2:0]           bus_mode = 3'd2;
  logic [BAW-1:0]       bus_addr = '0;
  logic [`XLEN-1:0]     bus_dat_i = '0;
  logic [`XLEN-1:0]     bus_dat_o;
  logic                 bus_ready;

  int vectors = 0;
  int miscompares = 0;

  ps2_kbd dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .bus_req(bus_req), .bus_wen(bus_wen), .bus_mode(bus_mode),
    .bus_addr(bus_addr), .bus_dat_i(bus_dat_i),
    .bus_dat_o(bus_dat_o), .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    tick(5);
    ps2_clk = 1'b0;
    tick(10);
    ps2_clk = 1'b1;
    tick(5);
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic bad_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit((~^code) ^ bad_par);
    ps2_bit(~bad_stop);
    ps2_data = 1'b1;
    tick(5);
  endtask

  // single bus transaction; ok = 0 if no ready pulse within the budget
  task automatic bus_xfer(input logic wen, input logic [BAW-1:0] addr, input logic [31:0] wdat,
                          output logic [31:0] rdat, output logic ok);
    rdat = 'x;
    ok = 1'b0;
    bus_req = 1'b1; bus_wen = wen; bus_addr = addr; bus_dat_i = wdat;
    tick(1);
    bus_req = 1'b0; bus_wen = 1'b0; bus_dat_i = '0;
    for (int i = 0; i < 4; i++) begin
      if (bus_ready) begin
        rdat = bus_dat_o;
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    tick(1);
  endtask

  task automatic check_rd(input string name, input logic [BAW-1:0] addr, input logic [31:0] exp);
    logic [31:0] r;
    logic ok;
    bus_xfer(1'b0, addr, 32'h0, r, ok);
    vectors++;
    if (!ok || r !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h (ready=%0b), expected %h", name, r, ok, exp);
    end
  endtask

  task automatic write_status(input logic [31:0] wdat);
    logic [31:0] r;
    logic ok;
    bus_xfer(1'b1, 'h4, wdat, r, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL write_ack: got ready=%0b, expected 1", ok);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(4);
    vectors++;
    if (bus_ready !== 1'b0 || bus_dat_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ready=%b dat=%h, expected 0/0", bus_ready, bus_dat_o);
    end
    rst = 1'b1;
    tick(2);
    check_rd("reset_status", 'h4, 32'h0);
  endtask

  task automatic test_single();
    send_frame(8'hAA, 1'b0, 1'b0);
    check_rd("single_status", 'h4, 32'h0000_0101);
    check_rd("single_data", 'h0, 32'h0000_00AA);
    check_rd("single_status_after", 'h4, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] codes [3];
    codes[0] = 8'h52; codes[1] = 8'hF0; codes[2] = 8'h52;
    for (int i = 0; i < 3; i++) send_frame(codes[i], 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) check_rd("b2b_data", 'h0, {24'h0, codes[i]});
    check_rd("b2b_underflow", 'h0, 32'h0);
    check_rd("b2b_status", 'h4, 32'h0);
  endtask

  task automatic test_held_req();
    logic exp_r [4];
    exp_r[0] = 1'b1; exp_r[1] = 1'b0; exp_r[2] = 1'b1; exp_r[3] = 1'b0;
    bus_req = 1'b1; bus_wen = 1'b0; bus_addr = 'h4;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (i == 2) bus_req = 1'b0;
      vectors++;
      if (bus_ready !== exp_r[i] || (!exp_r[i] && bus_dat_o !== 32'h0)) begin
        miscompares++;
        $display("FAIL held_req[%0d]: got ready=%b dat=%h, expected ready=%b", i, bus_ready, bus_dat_o, exp_r[i]);
      end
    end
    tick(2);
  endtask

  task automatic test_errors();
    send_frame(8'h1C, 1'b1, 1'b0);
    check_rd("parity_status", 'h4, 32'h0000_0008);
    write_status(32'h8);
    check_rd("parity_cleared", 'h4, 32'h0);
    send_frame(8'h1C, 1'b0, 1'b1);
    check_rd("stop_status", 'h4, 32'h0000_0008);
    write_status(32'h8);
    check_rd("stop_cleared", 'h4, 32'h0);
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
    check_rd("ovf_status", 'h4, 32'h0000_0807);
    for (int i = 1; i <= 8; i++) check_rd("ovf_data", 'h0, 32'(i));
    check_rd("ovf_sticky", 'h4, 32'h0000_0004);
    write_status(32'h4);
    check_rd("ovf_cleared", 'h4, 32'h0);
  endtask

  task automatic test_push_pop_full();
    logic [31:0] r;
    logic ok;
    for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b0);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(i == 4);
    ps2_bit(1'b0);
    ps2_data = 1'b1;
    tick(5);
    ps2_clk = 1'b0;
    // the receiver sees the fall after two synchroniser stages
    tick(2);
    bus_req = 1'b1; bus_wen = 1'b0; bus_addr = 'h0;
    tick(1);
    bus_req = 1'b0;
    r = bus_dat_o; ok = bus_ready;
    vectors++;
    if (!ok || r !== 32'h11) begin
      miscompares++;
      $display("FAIL simul_data: got %h (ready=%0b), expected 00000011", r, ok);
    end
    tick(9);
    ps2_clk = 1'b1;
    tick(5);
    check_rd("simul_status", 'h4, 32'h0000_0803);
    for (int i = 1; i < 8; i++) check_rd("simul_drain", 'h0, 32'h11 + 32'(i));
    check_rd("simul_last", 'h0, 32'h10);
  endtask

  task automatic test_mid_reset();
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(2);
    send_frame(8'h33, 1'b0, 1'b0);
    check_rd("midrst_status", 'h4, 32'h0000_0101);
    check_rd("midrst_data", 'h0, 32'h33);
    check_rd("midrst_empty", 'h4, 32'h0);
  endtask

`ifdef PS2_TIMEOUT_EN
  task automatic test_timeout();
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    tick(5100);
    check_rd("tout_status", 'h4, 32'h0000_0010);
    send_frame(8'h33, 1'b0, 1'b0);
    check_rd("tout_rx", 'h0, 32'h33);
    write_status(32'h10);
    check_rd("tout_cleared", 'h4, 32'h0);
  endtask
`endif

  initial begin
    tick(1);
    test_reset();
    test_single();
    test_back_to_back();
    test_held_req();
    test_errors();
    test_overflow();
    test_push_pop_full();
    test_mid_reset();
`ifdef PS2_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_kbd.md
Name: ps2_kbd

Overview:
PS/2 keyboard receiver and bus slave, sitting between the board PS/2 pins and the SoC bus fabric.
- Deserialises 11-bit device-to-host frames: start bit, 8 data bits LSB first, odd parity, stop bit.
- Queues valid scancodes in a small FIFO.
- Exposes DATA and STATUS registers to the CPU through the standard slave bus handshake.

Parameters:
FIFO_DEPTH, 8, scancode FIFO entries; power of 2, minimum 2.
SYNC_STAGES, 2, flip-flop stages on ps2_clk and ps2_data; minimum 2.
TIMEOUT_CYCLES, 5000, idle clk cycles before a partial frame is aborted (used only with PS2_TIMEOUT_EN).

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-low reset.
ps2_clk  in  1  raw PS/2 clock from the keyboard; asynchronous, idles high.
ps2_data  in  1  raw PS/2 data from the keyboard; asynchronous.
bus_req  in  1  slave select / request strobe.
bus_wen  in  1  1 = write, 0 = read.
bus_mode  in  3  access size; ignored, all accesses treated as 32-bit.
bus_addr  in  `XLEN-`SLAVE_WIDTH  byte offset within slave; only bits [2] decoded (0 = DATA, 1 = STATUS).
bus_dat_i  in  `XLEN  write data.
bus_dat_o  out  `XLEN  read data; valid while bus_ready = 1.
bus_ready  out  1  one-cycle completion pulse.

Behaviour:
Reset (rst = 0 at a clk edge):
- FSM returns to IDLE; any partial frame is discarded.
- FIFO is emptied; all sticky flags are cleared.
- Synchroniser stages are set to 1.
- bus_dat_o = 0, bus_ready = 0.

Edge detect:
- fall = previous synced ps2_clk is 1 and current synced ps2_clk is 0.
- ps2_data is sampled from its synchroniser output on the same cycle as fall.

FSM (advances only on fall):
- IDLE: data = 0 → DATA with bitcnt = 0. Data = 1 → stay in IDLE (spurious edge ignored).
- DATA: shift the sampled bit into shreg[7]; shreg shifts right, so the first data bit ends in shreg[0]. Increment bitcnt. After the 8th bit → PARITY.
- PARITY: par_ok = (^shreg) ^ sampled bit. Odd parity means par_ok = 1. → STOP.
- STOP, stop bit = 1 and par_ok = 1: push shreg into the FIFO → IDLE.
- STOP, par_ok = 0: set sticky PERR and drop the code → IDLE.
- STOP, stop bit = 0: frame error; set PERR and drop the code → IDLE.

FIFO:
- Read/write pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
- Push when full and no pop in the same cycle: code dropped, sticky OVF set.
- Push and pop in the same cycle: both take effect. When full, the push is accepted and OVF is not set.
- Pop when empty: no pointer change.

Bus handshake:
- bus_req sampled at cycle N → bus_ready = 1 at cycle N+1 for exactly one cycle, with bus_dat_o valid.
- bus_ready deasserts and bus_dat_o returns to 0 at N+2.
- bus_req held high produces a pulse every other cycle.
- Side effects (pop, W1C) occur at cycle N.

DATA (offset 0x0):
- Read returns {24'b0, head}. If the FIFO is not empty, it pops.
- Read when empty returns 0.
- Writes are ignored but still acknowledged.

STATUS (offset 0x4):
- Read layout: bit0 not-empty, bit1 full, bit2 OVF, bit3 PERR, bit4 TOUT, bits[15:8] FIFO count, all other bits 0.
- Write: bits 2/3/4 are write-1-to-clear.
- If a flag set event and a W1C land in the same cycle, set wins.

Optional Feature:
Macro PS2_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on every fall and in IDLE, and increments in the other states.
  - Reaching TIMEOUT_CYCLES returns the FSM to IDLE, discards the partial frame and sets sticky TOUT (STATUS bit4).
- Undefined:
  - No counter; a stalled frame waits indefinitely.
  - STATUS bit4 reads 0.

Test Plan:
1. Reset, then send 0xAA (parity 1), wait for idle, read STATUS → 0x0000_0101. Read DATA → 0x0000_00AA. STATUS → 0x0.
2. Send 0x52, 0xF0, 0x52 back-to-back, then read DATA three times → 0x52, 0xF0, 0x52. A fourth read → 0x0, no underflow.
3. Send 0x1C with inverted parity bit → FIFO empty, STATUS bit3 = 1. Write STATUS 0x8 → bit3 = 0.
4. Send FIFO_DEPTH+1 = 9 codes 0x01..0x09 without reading → STATUS count = 8, full = 1, OVF = 1. DATA reads return 0x01..0x08.
5. With FIFO full, issue a DATA read in the same cycle as the 0x10 frame's STOP fall → read returns the old head, count stays 8, OVF stays 0.
6. Assert rst = 0 after the 4th data bit of a frame, then send 0x33 → only 0x33 is queued. With PS2_TIMEOUT_EN defined, stopping ps2_clk after 3 bits for > 5000 cycles → TOUT = 1, and a following 0x33 is received intact.
